ifelse_arbiter: RTL and testbench

Parametrised, registered successor of the combinational if/else priority selector. N request lines compete for one grant. Selection is either a fixed-priority if/else chain or round-robin. The grant is held while the owner keeps requesting, with an optional forced hand-over after MAX_HOLD cycles. It sits in front of a shared resource, for example a bus or memory port, in lab designs.

---
 rtl/ifelse_arbiter.sv | 129 ++++++++++++
 tb/tb_ifelse_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ifelse_arbiter.sv
// Registered N-way arbiter: fixed-priority or round-robin selection, grant held while
// the owner keeps requesting, optional forced hand-over after MAX_HOLD cycles.
module ifelse_arbiter #(
   parameter int N        = 4,
   parameter int MODE     = 0,
   parameter int MAX_HOLD = 0,
   parameter int IDW      = (N > 1) ? $clog2(N) : 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   grant,
   output logic           grant_valid,
   output logic [IDW-1:0] grant_id
);

   localparam int HCW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD);
   localparam logic [HCW-1:0] HOLD_NEW = (MAX_HOLD > 0) ? HCW'(1) : '0;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t           state_q, state_d;
   logic [N-1:0]     grant_q, grant_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [HCW-1:0]   hold_q, hold_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]   win_all, win_oth;
   logic [N-1:0]     others;
   logic             own_req;

   // Loops run backwards so the first index in scan order is the last one assigned.
   function automatic logic [IDW-1:0] winner(input logic [N-1:0] vec,
                                             input logic [IDW-1:0] ptr);
      int idx;
      winner = '0;
      if (MODE == 0) begin
         for (int i = N - 1; i >= 0; i--)
            if (vec[i]) winner = IDW'(i);
      end else begin
         for (int i = N; i >= 1; i--) begin
            idx = (int'(ptr) + i) % N;
            if (vec[idx]) winner = IDW'(idx);
         end
      end
   endfunction

   function automatic logic [HCW-1:0] sat_inc(input logic [HCW-1:0] cnt);
      if (MAX_HOLD == 0)
         sat_inc = '0;
      else if (cnt < HOLD_MAX)
         sat_inc = cnt + 1'b1;
      else
         sat_inc = HOLD_MAX;
   endfunction

   assign others  = req & ~grant_q;
   assign own_req = |(req & grant_q);
   assign win_all = winner(req, rr_ptr_q);
   assign win_oth = winner(others, rr_ptr_q);

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      id_d     = id_q;
      hold_d   = hold_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d         = GRANT;
               grant_d         = '0;
               grant_d[win_all] = 1'b1;
               id_d            = win_all;
               rr_ptr_d        = win_all;
               hold_d          = HOLD_NEW;
            end
         end
         GRANT: begin
            if (!own_req) begin
               if (|req) begin
                  // Owner released while others wait: hand over without an idle bubble.
                  grant_d          = '0;
                  grant_d[win_all] = 1'b1;
                  id_d             = win_all;
                  rr_ptr_d         = win_all;
                  hold_d           = HOLD_NEW;
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
                  id_d    = '0;
                  hold_d  = '0;
               end
            end else if (MAX_HOLD > 0 && hold_q >= HOLD_MAX && |others) begin
               grant_d          = '0;
               grant_d[win_oth] = 1'b1;
               id_d             = win_oth;
               rr_ptr_d         = win_oth;
               hold_d           = HOLD_NEW;
            end else begin
               hold_d = sat_inc(hold_q);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Registered grant stage
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         id_q     <= '0;
         hold_q   <= '0;
         rr_ptr_q <= IDW'(N - 1);
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         id_q     <= id_d;
         hold_q   <= hold_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign grant       = grant_q;
   assign grant_valid = |grant_q;
   assign grant_id    = id_q;

endmodule

// File: tb/tb_ifelse_arbiter.sv
// Scoreboard bench for ifelse_arbiter: fixed priority (N=4), round-robin with
// MAX_HOLD=3 (N=4), and the single-requester case (N=1).
module tb_ifelse_arbiter;

   typedef struct {
      logic [3:0] g;
      logic       v;
      logic [1:0] id;
      string      nm;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
   logic [3:0] req_a = '0, req_b = '0;
   logic [0:0] req_c = '0;
   logic [3:0] grant_a, grant_b;
   logic [0:0] grant_c;
   logic       gv_a, gv_b, gv_c;
   logic [1:0] id_a, id_b;
   logic [0:0] id_c;

   exp_t q_a[$], q_b[$], q_c[$];
   exp_t ea, eb, ec;
   int   errors = 0;
   int   checks = 0;

   ifelse_arbiter #(.N(4), .MODE(0), .MAX_HOLD(0)) dut_a (
      .clk(clk), .reset(rst_a), .req(req_a),
      .grant(grant_a), .grant_valid(gv_a), .grant_id(id_a));

   ifelse_arbiter #(.N(4), .MODE(1), .MAX_HOLD(3)) dut_b (
      .clk(clk), .reset(rst_b), .req(req_b),
      .grant(grant_b), .grant_valid(gv_b), .grant_id(id_b));

   ifelse_arbiter #(.N(1), .MODE(0), .MAX_HOLD(2)) dut_c (
      .clk(clk), .reset(rst_c), .req(req_c),
      .grant(grant_c), .grant_valid(gv_c), .grant_id(id_c));

   function automatic logic [1:0] id_of(input logic [3:0] g);
      id_of = '0;
      for (int i = 0; i < 4; i++)
         if (g[i]) id_of = 2'(i);
   endfunction

   task automatic check(input string nm, input logic [3:0] ag, input logic av,
                        input logic [1:0] aid, input exp_t e);
      checks++;
      if (ag !== e.g || av !== e.v || aid !== e.id) begin
         errors++;
         $display("FAIL %s: got grant=%b valid=%b id=%0d, expected grant=%b valid=%b id=%0d",
                  nm, ag, av, aid, e.g, e.v, e.id);
      end
   endtask

   task automatic step_a(input logic r, input logic [3:0] rq, input logic [3:0] eg,
                         input string nm);
      @(negedge clk);
      rst_a = r; req_a = rq;
      q_a.push_back('{eg, |eg, id_of(eg), nm});
   endtask

   task automatic step_b(input logic r, input logic [3:0] rq, input logic [3:0] eg,
                         input string nm);
      @(negedge clk);
      rst_b = r; req_b = rq;
      q_b.push_back('{eg, |eg, id_of(eg), nm});
   endtask

   task automatic step_c(input logic r, input logic rq, input logic eg, input string nm);
      @(negedge clk);
      rst_c = r; req_c = rq;
      q_c.push_back('{{3'b000, eg}, eg, 2'b00, nm});
   endtask

   // Monitors: one expectation is consumed per registered output update.
   always @(posedge clk) begin
      #1;
      if (q_a.size() > 0) begin
         ea = q_a.pop_front();
         check({"A ", ea.nm}, grant_a, gv_a, id_a, ea);
      end
      if (q_b.size() > 0) begin
         eb = q_b.pop_front();
         check({"B ", eb.nm}, grant_b, gv_b, id_b, eb);
      end
      if (q_c.size() > 0) begin
         ec = q_c.pop_front();
         check({"C ", ec.nm}, {3'b000, grant_c}, gv_c, {1'b0, id_c}, ec);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Fixed priority, unlimited hold
      step_a(1'b1, 4'b1111, 4'b0000, "reset_hold1");
      step_a(1'b1, 4'b1111, 4'b0000, "reset_hold2");
      step_a(1'b0, 4'b1111, 4'b0001, "first_after_reset");
      step_a(1'b0, 4'b1010, 4'b0010, "owner_drop_to_1");
      step_a(1'b0, 4'b1000, 4'b1000, "direct_move_to_3");
      step_a(1'b0, 4'b1001, 4'b1000, "no_preempt_by_lower");
      step_a(1'b0, 4'b0000, 4'b0000, "drop_all_idle");
      step_a(1'b0, 4'b0001, 4'b0001, "regrant_0");
      step_a(1'b0, 4'b0100, 4'b0100, "move_to_2");
      for (int i = 0; i < 6; i++)
         step_a(1'b0, 4'b1111, 4'b0100, "unlimited_hold");
      step_a(1'b1, 4'b0000, 4'b0000, "park_reset");

      // Round-robin with forced hand-over after 3 cycles
      step_b(1'b1, 4'b1111, 4'b0000, "reset");
      for (int i = 0; i < 13; i++)
         step_b(1'b0, 4'b1111, 4'(1 << ((i / 3) % 4)), "rr_rotate");
      for (int i = 0; i < 10; i++)
         step_b(1'b0, 4'b0100, 4'b0100, "sole_requester_hold");
      step_b(1'b1, 4'b1111, 4'b0000, "mid_grant_reset");
      step_b(1'b0, 4'b1111, 4'b0001, "ptr_reset_first");
      step_b(1'b0, 4'b1010, 4'b0010, "rr_next_after_0");
      step_b(1'b0, 4'b1001, 4'b1000, "rr_skip_to_3");
      step_b(1'b0, 4'b0000, 4'b0000, "rr_idle");
      step_b(1'b1, 4'b0000, 4'b0000, "park_reset");

      // Single requester: never forced off
      step_c(1'b1, 1'b1, 1'b0, "reset");
      for (int i = 0; i < 5; i++)
         step_c(1'b0, 1'b1, 1'b1, "hold_single");
      step_c(1'b0, 1'b0, 1'b0, "drop_single");
      step_c(1'b0, 1'b1, 1'b1, "regrant_single");

      repeat (3) @(negedge clk);
      checks++;
      if (q_a.size() + q_b.size() + q_c.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0",
                  q_a.size() + q_b.size() + q_c.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
